fetch_stage: RTL and testbench

//   Instruction-fetch stage of the single-cycle-to-pipelined datapath. Owns the

---
 rtl/fetch_stage.sv | 97 +++++++++
 tb/tb_fetch_stage.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses a combinational instruction memory and
// registers the returned word into an IF/ID register with valid/ready, stall and redirect.
module fetch_stage #(
    parameter int          ADDR_W   = 5,
    parameter int          DATA_W   = 32,
    parameter int unsigned RESET_PC = 0,
    parameter int          CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    input  logic              id_ready,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_pc_plus1,
    output logic [CNT_W-1:0]  fetch_count,
    output logic [1:0]        fsm_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        STALL = 2'b10
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt;
    logic              valid_nxt;
    logic [DATA_W-1:0] instr_nxt;
    logic [ADDR_W-1:0] if_pc_nxt;
    logic [CNT_W-1:0]  count_nxt;
    logic              handshake;
    logic              accept;

    assign handshake   = if_valid & id_ready;
    assign accept      = ~if_valid | id_ready;
    assign imem_addr   = pc;
    assign if_pc_plus1 = if_pc + ADDR_W'(1);
    assign fsm_state   = state;

    // A word consumed in the same cycle as a redirect still counts as delivered.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        valid_nxt = if_valid;
        instr_nxt = if_instr;
        if_pc_nxt = if_pc;
        count_nxt = handshake ? fetch_count + CNT_W'(1) : fetch_count;
        case (state)
            IDLE: begin
                state_nxt = RUN;
            end
            RUN, STALL: begin
                if (branch_taken) begin
                    pc_nxt    = branch_target;
                    valid_nxt = 1'b0;
                    state_nxt = RUN;
                end else if (accept) begin
                    instr_nxt = imem_data;
                    if_pc_nxt = pc;
                    valid_nxt = 1'b1;
                    pc_nxt    = pc + ADDR_W'(1);
                    state_nxt = RUN;
                end else begin
                    state_nxt = STALL;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // IF/ID boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= ADDR_W'(RESET_PC);
            if_valid    <= 1'b0;
            if_instr    <= '0;
            if_pc       <= '0;
            fetch_count <= '0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            if_valid    <= valid_nxt;
            if_instr    <= instr_nxt;
            if_pc       <= if_pc_nxt;
            fetch_count <= count_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed stimulus pushes expected delivered words,
// a negedge monitor pops and compares on every IF/ID handshake.
module tb_fetch_stage;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_data;
    logic              id_ready;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_target;
    logic              if_valid;
    logic [DATA_W-1:0] if_instr;
    logic [ADDR_W-1:0] if_pc;
    logic [ADDR_W-1:0] if_pc_plus1;
    logic [CNT_W-1:0]  fetch_count;
    logic [1:0]        fsm_state;

    typedef struct {
        logic [DATA_W-1:0] instr;
        logic [ADDR_W-1:0] pc;
    } exp_t;

    exp_t              sb_q[$];
    logic [DATA_W-1:0] mem [32];
    int                n_tests = 0;
    int                n_fail  = 0;

    fetch_stage #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(0), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .id_ready      (id_ready),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .if_valid      (if_valid),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .if_pc_plus1   (if_pc_plus1),
        .fetch_count   (fetch_count),
        .fsm_state     (fsm_state)
    );

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr];

    function automatic logic [DATA_W-1:0] word(input int i);
        return 32'hA5A5_0000 | DATA_W'(i);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push(input int i);
        exp_t e;
        e.instr = word(i);
        e.pc    = ADDR_W'(i);
        sb_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every handshake must match the oldest expected delivery
    always @(negedge clk) begin
        if (rst_n === 1'b1 && if_valid === 1'b1 && id_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_handshake_pc", 32'(if_pc), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                logic [ADDR_W-1:0] p1;
                e  = sb_q.pop_front();
                p1 = e.pc + ADDR_W'(1);
                chk("sb_instr", if_instr, e.instr);
                chk("sb_pc", 32'(if_pc), 32'(e.pc));
                chk("sb_pc_plus1", 32'(if_pc_plus1), 32'(p1));
            end
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = word(i);
        rst_n         = 1'b0;
        id_ready      = 1'b1;
        branch_taken  = 1'b0;
        branch_target = '0;

        // Reset state and sequential fetch
        step();
        step();
        chk("rst_valid", 32'(if_valid), 0);
        chk("rst_instr", if_instr, 0);
        chk("rst_pc", 32'(if_pc), 0);
        chk("rst_count", 32'(fetch_count), 0);
        chk("rst_state", 32'(fsm_state), 0);
        chk("rst_addr", 32'(imem_addr), 0);
        for (int i = 0; i < 8; i++) push(i);
        rst_n = 1'b1;
        step();
        chk("idle_state", 32'(fsm_state), 1);
        chk("idle_valid", 32'(if_valid), 0);
        chk("idle_addr", 32'(imem_addr), 0);
        step();
        chk("first_instr", if_instr, word(0));
        chk("first_valid", 32'(if_valid), 1);
        for (int i = 0; i < 8; i++) step();
        id_ready = 1'b0;
        chk("count8", 32'(fetch_count), 8);
        chk("seq_instr8", if_instr, word(8));

        // Stall holds everything stable
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_state", 32'(fsm_state), 2);
            chk("stall_instr", if_instr, word(8));
            chk("stall_pc", 32'(if_pc), 8);
            chk("stall_addr", 32'(imem_addr), 9);
            chk("stall_count", 32'(fetch_count), 8);
            chk("stall_valid", 32'(if_valid), 1);
        end
        push(8);
        id_ready = 1'b1;
        step();
        chk("release_instr", if_instr, word(9));
        chk("release_count", 32'(fetch_count), 9);
        push(9);
        step();
        chk("release_count2", 32'(fetch_count), 10);

        // Branch under back-pressure flushes without counting
        id_ready      = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 5'd20;
        step();
        chk("br_stall_valid", 32'(if_valid), 0);
        chk("br_stall_count", 32'(fetch_count), 10);
        chk("br_stall_addr", 32'(imem_addr), 20);
        branch_taken = 1'b0;
        id_ready     = 1'b1;
        step();
        chk("br_target_instr", if_instr, word(20));
        chk("br_target_pc", 32'(if_pc), 20);
        chk("br_target_count", 32'(fetch_count), 10);

        // Branch with a same-cycle handshake
        push(20);
        branch_taken  = 1'b1;
        branch_target = 5'd3;
        step();
        chk("br_hs_count", 32'(fetch_count), 11);
        chk("br_hs_valid", 32'(if_valid), 0);
        branch_taken = 1'b0;
        step();
        chk("br_hs_pc", 32'(if_pc), 3);
        chk("br_hs_instr", if_instr, word(3));

        // PC wrap 30,31,0,1
        push(3);
        branch_taken  = 1'b1;
        branch_target = 5'd30;
        step();
        chk("wrap_br_count", 32'(fetch_count), 12);
        branch_taken = 1'b0;
        step();
        chk("wrap_start_pc", 32'(if_pc), 30);
        push(30);
        push(31);
        push(0);
        push(1);
        for (int i = 0; i < 4; i++) step();
        id_ready = 1'b0;
        chk("wrap_count", 32'(fetch_count), 16);
        chk("wrap_end_pc", 32'(if_pc), 2);

        // Asynchronous reset mid-cycle during STALL
        step();
        chk("pre_rst_state", 32'(fsm_state), 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(if_valid), 0);
        chk("async_instr", if_instr, 0);
        chk("async_count", 32'(fetch_count), 0);
        chk("async_state", 32'(fsm_state), 0);
        chk("async_addr", 32'(imem_addr), 0);
        step();
        rst_n         = 1'b1;
        id_ready      = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 5'd17;
        step();
        chk("idle_br_ignored_addr", 32'(imem_addr), 0);
        chk("idle_br_state", 32'(fsm_state), 1);
        branch_taken = 1'b0;
        push(0);
        step();
        chk("restart_instr", if_instr, word(0));
        chk("restart_pc", 32'(if_pc), 0);
        step();
        id_ready = 1'b0;
        chk("restart_count", 32'(fetch_count), 1);
        @(negedge clk);
        chk("sb_drained", 32'(sb_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
